// File: rtl/fd_hazard_if.sv
// Handshake bundle between the pipeline datapath and the fetch/decode hazard controller.
// The master side drives hazard sources; the slave (controller) drives sequencing controls.
interface fd_hazard_if;
  logic [2:0] rs_d;
  logic       rs_vld_d;
  logic [2:0] rt_d;
  logic       rt_vld_d;
  logic       halt_d;
  logic [2:0] rd_x;
  logic       regwr_x;
  logic       memrd_x;
  logic [2:0] rd_m;
  logic       regwr_m;
  logic [2:0] rd_w;
  logic       regwr_w;
  logic       br_taken_x;
  logic       imem_stall;
  logic       pc_we;
  logic       fd_we;
  logic       fd_nop;
  logic       dx_nop;
  logic       halted;

  modport master (
    output rs_d, rs_vld_d, rt_d, rt_vld_d, halt_d, rd_x, regwr_x, memrd_x,
           rd_m, regwr_m, rd_w, regwr_w, br_taken_x, imem_stall,
    input  pc_we, fd_we, fd_nop, dx_nop, halted
  );

  modport slave (
    input  rs_d, rs_vld_d, rt_d, rt_vld_d, halt_d, rd_x, regwr_x, memrd_x,
           rd_m, regwr_m, rd_w, regwr_w, br_taken_x, imem_stall,
    output pc_we, fd_we, fd_nop, dx_nop, halted
  );
endinterface

// File: rtl/fd_hazard_controller.sv
// Fetch/decode sequencing controller: picks advance/hold/squash/freeze for the PC and
// F/D latch each cycle and keeps saturating stall and flush counters.
//
// state | meaning
// RUN   | normal sequencing, hazard priority applied every cycle
// HALT  | HALT passed into X; pipe frozen until reset
module fd_hazard_controller #(
  parameter int FWD_EN    = 1,
  parameter int WB_BYPASS = 1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  fd_hazard_if.slave       hz,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic {RUN, HALT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             match_x, match_m, match_w;
  logic             load_use, raw_haz, data_haz;
  logic             stall_inc, flush_inc;
  logic             pc_we, fd_we, fd_nop, dx_nop;

  assign match_x = (hz.rs_vld_d && (hz.rs_d == hz.rd_x)) || (hz.rt_vld_d && (hz.rt_d == hz.rd_x));
  assign match_m = (hz.rs_vld_d && (hz.rs_d == hz.rd_m)) || (hz.rt_vld_d && (hz.rt_d == hz.rd_m));
  assign match_w = (hz.rs_vld_d && (hz.rs_d == hz.rd_w)) || (hz.rt_vld_d && (hz.rt_d == hz.rd_w));

  assign load_use = hz.memrd_x && hz.regwr_x && match_x;
  assign raw_haz  = (hz.regwr_x && match_x) || (hz.regwr_m && match_m) ||
                    ((WB_BYPASS == 0) && hz.regwr_w && match_w);
  assign data_haz = (FWD_EN != 0) ? load_use : raw_haz;

  // A taken branch wins over everything: the stall/hazard/halt sources are wrong-path.
  always_comb begin
    state_d   = state_q;
    pc_we     = 1'b0;
    fd_we     = 1'b0;
    fd_nop    = 1'b1;
    dx_nop    = 1'b1;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    if (rst && (state_q == RUN)) begin
      if (hz.br_taken_x) begin
        pc_we     = 1'b1;
        fd_we     = 1'b1;
        flush_inc = 1'b1;
      end else if (hz.imem_stall) begin
        fd_we     = 1'b1;
        dx_nop    = 1'b0;
        stall_inc = 1'b1;
      end else if (data_haz) begin
        fd_nop    = 1'b0;
        stall_inc = 1'b1;
      end else if (hz.halt_d) begin
        fd_nop    = 1'b0;
        dx_nop    = 1'b0;
        state_d   = HALT;
      end else begin
        pc_we     = 1'b1;
        fd_we     = 1'b1;
        fd_nop    = 1'b0;
        dx_nop    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}}))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_inc && (flush_cnt_q != {CNT_W{1'b1}}))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign hz.pc_we  = pc_we;
  assign hz.fd_we  = fd_we;
  assign hz.fd_nop = fd_nop;
  assign hz.dx_nop = dx_nop;
  assign hz.halted = rst && (state_q == HALT);
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_fd_hazard_controller.sv
// Self-checking bench: four controller configurations driven in parallel by the same
// stimulus, checked against vector tables, hand sequences and a rule-level reference model.
module tb_fd_hazard_controller;
  localparam int NI = 4;
  localparam int FW [NI] = '{1, 0, 0, 1};
  localparam int BY [NI] = '{1, 1, 0, 1};
  localparam int CW [NI] = '{16, 16, 16, 4};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] rs_d, rt_d, rd_x, rd_m, rd_w;
  logic       rs_vld_d, rt_vld_d, halt_d, regwr_x, memrd_x, regwr_m, regwr_w;
  logic       br_taken_x, imem_stall;

  logic [NI-1:0] pc_we_a, fd_we_a, fd_nop_a, dx_nop_a, halted_a;
  logic [15:0]   sc_a [NI];
  logic [15:0]   fc_a [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    fd_hazard_if hz ();
    logic [CW[g]-1:0] sc_n, fc_n;
    assign hz.rs_d       = rs_d;
    assign hz.rs_vld_d   = rs_vld_d;
    assign hz.rt_d       = rt_d;
    assign hz.rt_vld_d   = rt_vld_d;
    assign hz.halt_d     = halt_d;
    assign hz.rd_x       = rd_x;
    assign hz.regwr_x    = regwr_x;
    assign hz.memrd_x    = memrd_x;
    assign hz.rd_m       = rd_m;
    assign hz.regwr_m    = regwr_m;
    assign hz.rd_w       = rd_w;
    assign hz.regwr_w    = regwr_w;
    assign hz.br_taken_x = br_taken_x;
    assign hz.imem_stall = imem_stall;
    assign pc_we_a[g]    = hz.pc_we;
    assign fd_we_a[g]    = hz.fd_we;
    assign fd_nop_a[g]   = hz.fd_nop;
    assign dx_nop_a[g]   = hz.dx_nop;
    assign halted_a[g]   = hz.halted;
    assign sc_a[g]       = 16'(sc_n);
    assign fc_a[g]       = 16'(fc_n);
    fd_hazard_controller #(.FWD_EN(FW[g]), .WB_BYPASS(BY[g]), .CNT_W(CW[g])) u_dut (
      .clk(clk), .rst(rst), .hz(hz), .stall_cnt(sc_n), .flush_cnt(fc_n)
    );
  end

  int total = 0;
  int bad   = 0;
  bit mh  [NI];
  int msc [NI];
  int mfc [NI];

  // {pc_we, fd_we, fd_nop, dx_nop}
  localparam logic [3:0] C_RUN = 4'b1100, C_BR = 4'b1111, C_IMS = 4'b0110,
                         C_HAZ = 4'b0001, C_HLT = 4'b0000, C_OFF = 4'b0011;

  typedef struct {
    logic [2:0] rs; logic rsv; logic [2:0] rt; logic rtv;
    logic [2:0] rdx; logic wx; logic lx;
    logic [2:0] rdm; logic wm; logic [2:0] rdw; logic ww;
    logic br; logic ims;
    logic [3:0] e [3];
  } vec_t;

  function automatic vec_t mk(int rs, int rsv, int rt, int rtv, int rdx, int wx, int lx,
                              int rdm, int wm, int rdw, int ww, int br, int ims,
                              logic [3:0] e0, logic [3:0] e1, logic [3:0] e2);
    vec_t v;
    v.rs = 3'(rs); v.rsv = rsv[0]; v.rt = 3'(rt); v.rtv = rtv[0];
    v.rdx = 3'(rdx); v.wx = wx[0]; v.lx = lx[0];
    v.rdm = 3'(rdm); v.wm = wm[0]; v.rdw = 3'(rdw); v.ww = ww[0];
    v.br = br[0]; v.ims = ims[0];
    v.e[0] = e0; v.e[1] = e1; v.e[2] = e2;
    return v;
  endfunction

  function automatic bit reads(logic [2:0] r);
    return (rs_vld_d && rs_d == r) || (rt_vld_d && rt_d == r);
  endfunction

  // Expected controls from the priority rules, viewing X/M/W as a list of producers.
  function automatic logic [3:0] m_ctl(int g);
    logic [2:0] dst [3];
    bit         wr  [3];
    bit         haz;
    if (!rst || mh[g]) return C_OFF;
    haz = 1'b0;
    if (FW[g] != 0) begin
      haz = memrd_x && regwr_x && reads(rd_x);
    end else begin
      dst = '{rd_x, rd_m, rd_w};
      wr  = '{regwr_x, regwr_m, regwr_w && (BY[g] == 0)};
      for (int k = 0; k < 3; k++) if (wr[k] && reads(dst[k])) haz = 1'b1;
    end
    if (br_taken_x) return C_BR;
    if (imem_stall) return C_IMS;
    if (haz)        return C_HAZ;
    if (halt_d)     return C_HLT;
    return C_RUN;
  endfunction

  function automatic int sat_inc(int v, int g);
    return (v < (1 << CW[g]) - 1) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    for (int g = 0; g < NI; g++) begin mh[g] = 1'b0; msc[g] = 0; mfc[g] = 0; end
  endtask

  task automatic model_edge();
    logic [3:0] c;
    for (int g = 0; g < NI; g++) begin
      c = m_ctl(g);
      if (rst && !mh[g]) begin
        if (c == C_BR) mfc[g] = sat_inc(mfc[g], g);
        else if (c == C_IMS || c == C_HAZ) msc[g] = sat_inc(msc[g], g);
        else if (c == C_HLT) mh[g] = 1'b1;
      end
    end
  endtask

  task automatic chk(string nm, int g, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", nm, g, $time, act, exp);
    end
  endtask

  task automatic check_all();
    for (int g = 0; g < NI; g++) begin
      chk("ctl", g, 32'({pc_we_a[g], fd_we_a[g], fd_nop_a[g], dx_nop_a[g]}), 32'(m_ctl(g)));
      chk("halted", g, 32'(halted_a[g]), 32'(rst && mh[g]));
      chk("stall_cnt", g, 32'(sc_a[g]), 32'(msc[g]));
      chk("flush_cnt", g, 32'(fc_a[g]), 32'(mfc[g]));
    end
  endtask

  task automatic step();
    #1 check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_idle();
    rs_d = 0; rs_vld_d = 0; rt_d = 0; rt_vld_d = 0; halt_d = 0;
    rd_x = 0; regwr_x = 0; memrd_x = 0; rd_m = 0; regwr_m = 0;
    rd_w = 0; regwr_w = 0; br_taken_x = 0; imem_stall = 0;
  endtask

  task automatic rand_inputs(int halt_pct);
    rs_d = 3'($urandom_range(0, 3)); rs_vld_d = 1'($urandom);
    rt_d = 3'($urandom_range(0, 3)); rt_vld_d = 1'($urandom);
    rd_x = 3'($urandom_range(0, 3)); regwr_x = 1'($urandom); memrd_x = 1'($urandom);
    rd_m = 3'($urandom_range(0, 3)); regwr_m = 1'($urandom);
    rd_w = 3'($urandom_range(0, 3)); regwr_w = 1'($urandom);
    br_taken_x = ($urandom_range(0, 7) == 0);
    imem_stall = ($urandom_range(0, 5) == 0);
    halt_d     = ($urandom_range(0, 99) < halt_pct);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    vec_t vecs [10];
    vecs[0] = mk(0,0,0,0, 0,0,0, 0,0, 0,0, 0,0, C_RUN, C_RUN, C_RUN);
    vecs[1] = mk(3,1,0,0, 3,1,1, 0,0, 0,0, 0,0, C_HAZ, C_HAZ, C_HAZ);
    vecs[2] = mk(3,1,0,0, 3,1,0, 0,0, 0,0, 0,0, C_RUN, C_HAZ, C_HAZ);
    vecs[3] = mk(0,0,5,1, 0,0,0, 5,1, 0,0, 0,0, C_RUN, C_HAZ, C_HAZ);
    vecs[4] = mk(0,0,5,1, 0,0,0, 0,0, 5,1, 0,0, C_RUN, C_RUN, C_HAZ);
    vecs[5] = mk(0,0,5,0, 0,0,0, 5,1, 0,0, 0,0, C_RUN, C_RUN, C_RUN);
    vecs[6] = mk(2,1,0,0, 2,1,1, 0,0, 0,0, 0,1, C_IMS, C_IMS, C_IMS);
    vecs[7] = mk(2,1,0,0, 2,1,1, 0,0, 0,0, 1,1, C_BR,  C_BR,  C_BR);
    vecs[8] = mk(4,1,0,0, 4,0,1, 0,0, 0,0, 0,0, C_RUN, C_RUN, C_RUN);
    vecs[9] = mk(0,1,0,0, 0,1,1, 0,0, 0,0, 0,0, C_HAZ, C_HAZ, C_HAZ);

    // reset with noisy inputs, then five hazard-free cycles
    rst = 1'b0; model_reset(); rand_inputs(50);
    @(negedge clk);
    step(); rand_inputs(50); step();
    rst = 1'b1; set_idle();
    repeat (5) step();

    foreach (vecs[i]) begin
      rs_d = vecs[i].rs; rs_vld_d = vecs[i].rsv; rt_d = vecs[i].rt; rt_vld_d = vecs[i].rtv;
      rd_x = vecs[i].rdx; regwr_x = vecs[i].wx; memrd_x = vecs[i].lx;
      rd_m = vecs[i].rdm; regwr_m = vecs[i].wm; rd_w = vecs[i].rdw; regwr_w = vecs[i].ww;
      br_taken_x = vecs[i].br; imem_stall = vecs[i].ims; halt_d = 1'b0;
      #1;
      for (int g = 0; g < NI; g++)
        chk($sformatf("vec%0d", i), g,
            32'({pc_we_a[g], fd_we_a[g], fd_nop_a[g], dx_nop_a[g]}), 32'(vecs[i].e[g % 3]));
      step();
    end

    // branch overrides stall and halt; then halt alone freezes the pipe
    set_idle(); br_taken_x = 1; imem_stall = 1; halt_d = 1;
    step();
    set_idle(); halt_d = 1;
    step();
    set_idle();
    step();
    for (int g = 0; g < NI; g++) chk("halt_entered", g, 32'(halted_a[g]), 32'd1);
    repeat (10) begin rand_inputs(50); step(); end

    // asynchronous reset mid-halt
    rand_inputs(50);
    #2 rst = 1'b0; model_reset();
    #1 check_all();
    for (int g = 0; g < NI; g++) chk("async_rst_cnt", g, 32'(sc_a[g]), 32'd0);
    @(posedge clk); model_edge(); @(negedge clk);
    rst = 1'b1;

    for (int n = 0; n < 400; n++) begin
      rand_inputs(3);
      if ($urandom_range(0, 24) == 0 || (mh[0] && mh[1] && mh[2])) begin
        rst = 1'b0; model_reset();
      end else begin
        rst = 1'b1;
      end
      step();
    end

    // saturation of the narrow counter instance
    rst = 1'b0; model_reset(); set_idle();
    step();
    rst = 1'b1; imem_stall = 1;
    repeat ((1 << CW[3]) + 3) step();
    chk("stall_sat", 3, 32'(sc_a[3]), 32'((1 << CW[3]) - 1));
    chk("stall_sat_ctl", 3, 32'({pc_we_a[3], fd_nop_a[3]}), 32'b01);
    set_idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
